// File: rtl/hazard_scoreboard.sv
// N-way ID-stage hazard detector and forwarding-select unit with private EX/MEM dest shadows.
// Combinational decisions, zero latency; optional stats counters under HAZ_STATS_EN.
module hazard_scoreboard #(
  parameter int WAYS  = 3,
  parameter int REG_W = 5,
  parameter int FW    = 2 + $clog2(WAYS)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [WAYS-1:0]               id_valid,
  input  logic [WAYS*REG_W-1:0]         id_rs1,
  input  logic [WAYS*REG_W-1:0]         id_rs2,
  input  logic [WAYS-1:0]               id_rs1_used,
  input  logic [WAYS-1:0]               id_rs2_used,
  input  logic [WAYS*REG_W-1:0]         id_dest,
  input  logic [WAYS-1:0]               id_wr,
  input  logic [WAYS-1:0]               id_rd_mem,
  input  logic                          stall_in,
  input  logic                          flush,
  output logic [$clog2(WAYS+1)-1:0]     issue_count,
  output logic [WAYS*FW-1:0]            fwd_a,
  output logic [WAYS*FW-1:0]            fwd_b,
  output logic                          load_use
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]                   rollback_cnt,
  output logic [31:0]                   load_use_cnt
`endif
);

  localparam int CW = $clog2(WAYS+1);

  logic [WAYS-1:0]            ex_vld, ex_wr, ex_ld;
  logic [WAYS-1:0]            mem_vld, mem_wr, mem_ld;
  logic [WAYS-1:0][REG_W-1:0] ex_dest, mem_dest;

  logic [WAYS-1:0] blocked;
  logic [WAYS-1:0] lu_way;

  function automatic logic hit(input logic used, input logic pv, input logic pwr,
                               input logic [REG_W-1:0] pd, input logic [REG_W-1:0] src);
    return used & pv & pwr & (pd == src) & (pd != '0);
  endfunction

  function automatic logic [FW-1:0] fsel(input logic [1:0] st, input int k);
    logic [FW-1:0] f;
    f = FW'(st) << (FW - 2);
    f = f | FW'(k);
    return f;
  endfunction

  // Per-way blocking reasons: invalid, intra-bundle RAW, load-use against EX.
  always_comb begin
    blocked = '0;
    lu_way  = '0;
    for (int i = 0; i < WAYS; i++) begin
      blocked[i] = ~id_valid[i];
      for (int j = 0; j < i; j++) begin
        if (hit(id_rs1_used[i], id_valid[j], id_wr[j], id_dest[j*REG_W +: REG_W], id_rs1[i*REG_W +: REG_W]) ||
            hit(id_rs2_used[i], id_valid[j], id_wr[j], id_dest[j*REG_W +: REG_W], id_rs2[i*REG_W +: REG_W]))
          blocked[i] = 1'b1;
      end
      for (int k = 0; k < WAYS; k++) begin
        if (hit(id_rs1_used[i], ex_vld[k], ex_wr[k] & ex_ld[k], ex_dest[k], id_rs1[i*REG_W +: REG_W]) ||
            hit(id_rs2_used[i], ex_vld[k], ex_wr[k] & ex_ld[k], ex_dest[k], id_rs2[i*REG_W +: REG_W]))
          lu_way[i] = 1'b1;
      end
      blocked[i] = blocked[i] | lu_way[i];
    end
  end

  always_comb begin
    issue_count = CW'(WAYS);
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (blocked[i]) issue_count = CW'(i);
    end
    load_use = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if ((CW'(i) == issue_count) && id_valid[i] && lu_way[i]) load_use = 1'b1;
    end
  end

  // Later assignments win: MEM then EX, each scanned oldest to youngest way.
  always_comb begin
    logic [FW-1:0] sa, sb;
    fwd_a = '0;
    fwd_b = '0;
    for (int i = 0; i < WAYS; i++) begin
      sa = '0;
      sb = '0;
      for (int k = 0; k < WAYS; k++) begin
        if (hit(id_rs1_used[i], mem_vld[k], mem_wr[k], mem_dest[k], id_rs1[i*REG_W +: REG_W])) sa = fsel(2'b10, k);
        if (hit(id_rs2_used[i], mem_vld[k], mem_wr[k], mem_dest[k], id_rs2[i*REG_W +: REG_W])) sb = fsel(2'b10, k);
      end
      for (int k = 0; k < WAYS; k++) begin
        if (!ex_ld[k] && hit(id_rs1_used[i], ex_vld[k], ex_wr[k], ex_dest[k], id_rs1[i*REG_W +: REG_W])) sa = fsel(2'b01, k);
        if (!ex_ld[k] && hit(id_rs2_used[i], ex_vld[k], ex_wr[k], ex_dest[k], id_rs2[i*REG_W +: REG_W])) sb = fsel(2'b01, k);
      end
      if (CW'(i) < issue_count) begin
        fwd_a[i*FW +: FW] = sa;
        fwd_b[i*FW +: FW] = sb;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_vld   <= '0;
      ex_wr    <= '0;
      ex_ld    <= '0;
      ex_dest  <= '0;
      mem_vld  <= '0;
      mem_wr   <= '0;
      mem_ld   <= '0;
      mem_dest <= '0;
    end else if (flush) begin
      ex_vld  <= '0;
      mem_vld <= '0;
    end else if (!stall_in) begin
      mem_vld  <= ex_vld;
      mem_wr   <= ex_wr;
      mem_ld   <= ex_ld;
      mem_dest <= ex_dest;
      for (int k = 0; k < WAYS; k++) begin
        ex_vld[k]  <= (CW'(k) < issue_count);
        ex_dest[k] <= id_dest[k*REG_W +: REG_W];
      end
      ex_wr <= id_wr;
      ex_ld <= id_rd_mem;
    end
  end

`ifdef HAZ_STATS_EN
  logic [CW-1:0] n_valid;

  always_comb begin
    n_valid = '0;
    for (int i = 0; i < WAYS; i++) n_valid = n_valid + CW'(id_valid[i]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rollback_cnt <= '0;
      load_use_cnt <= '0;
    end else if (!stall_in) begin
      if ((issue_count < n_valid) && (rollback_cnt != '1)) rollback_cnt <= rollback_cnt + 32'd1;
      if (load_use && (load_use_cnt != '1)) load_use_cnt <= load_use_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard (WAYS=3): directed scenarios plus random bundles vs a producer-list model.
module tb_hazard_scoreboard;

  localparam int WAYS = 3;
  localparam int RW   = 5;
  localparam int FW   = 4;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [WAYS-1:0]      id_valid, id_rs1_used, id_rs2_used, id_wr, id_rd_mem;
  logic [WAYS*RW-1:0]   id_rs1, id_rs2, id_dest;
  logic                 stall_in, flush;
  logic [1:0]           issue_count;
  logic [WAYS*FW-1:0]   fwd_a, fwd_b;
  logic                 load_use;

  hazard_scoreboard #(.WAYS(WAYS), .REG_W(RW)) dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_dest(id_dest), .id_wr(id_wr), .id_rd_mem(id_rd_mem),
    .stall_in(stall_in), .flush(flush), .issue_count(issue_count),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use(load_use)
  );

  always #5 clock = ~clock;

  typedef struct { bit v; int dest; bit wr; bit ld; } ent_t;
  ent_t ex_m[WAYS];
  ent_t mem_m[WAYS];

  int checks = 0;
  int failures = 0;
  int exp_ic, exp_fa, exp_fb;
  bit exp_lu;
  logic [31:0] saved_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_hit(input int src, input bit used, input ent_t e);
    return used && e.v && e.wr && (e.dest == src) && (src != 0);
  endfunction

  function automatic ent_t id_ent(input int j);
    ent_t e;
    e.v = id_valid[j]; e.dest = int'(id_dest[j*RW +: RW]); e.wr = id_wr[j]; e.ld = id_rd_mem[j];
    return e;
  endfunction

  // Producers listed youngest first; first usable match is the forwarding source.
  function automatic int pick(input int src, input bit used);
    for (int p = 0; p < 2*WAYS; p++) begin
      ent_t e;
      int k;
      k = WAYS - 1 - (p % WAYS);
      e = (p < WAYS) ? ex_m[k] : mem_m[k];
      if (m_hit(src, used, e) && !(p < WAYS && e.ld)) return (p < WAYS) ? (4 | k) : (8 | k);
    end
    return 0;
  endfunction

  task automatic predict();
    exp_ic = WAYS; exp_lu = 0; exp_fa = 0; exp_fb = 0;
    for (int i = 0; i < WAYS; i++) begin
      int r1, r2;
      bit ra, rb, rc;
      r1 = int'(id_rs1[i*RW +: RW]); r2 = int'(id_rs2[i*RW +: RW]);
      ra = !id_valid[i]; rb = 0; rc = 0;
      for (int j = 0; j < i; j++)
        if (m_hit(r1, id_rs1_used[i], id_ent(j)) || m_hit(r2, id_rs2_used[i], id_ent(j))) rb = 1;
      for (int k = 0; k < WAYS; k++)
        if (ex_m[k].ld && (m_hit(r1, id_rs1_used[i], ex_m[k]) || m_hit(r2, id_rs2_used[i], ex_m[k]))) rc = 1;
      if (ra || rb || rc) begin
        exp_ic = i;
        exp_lu = !ra && rc;
        break;
      end
    end
    for (int i = 0; i < exp_ic; i++) begin
      exp_fa |= pick(int'(id_rs1[i*RW +: RW]), id_rs1_used[i]) << (FW*i);
      exp_fb |= pick(int'(id_rs2[i*RW +: RW]), id_rs2_used[i]) << (FW*i);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < WAYS; k++) begin
      ex_m[k].v = 0; mem_m[k].v = 0;
    end
  endtask

  task automatic settle();
    #1;
    predict();
    chk("issue_count", 32'(issue_count), 32'(exp_ic));
    chk("load_use", 32'(load_use), 32'(exp_lu));
    chk("fwd_a", 32'(fwd_a), exp_fa);
    chk("fwd_b", 32'(fwd_b), exp_fb);
  endtask

  task automatic advance();
    @(posedge clock);
    if (flush) clear_model();
    else if (!stall_in) begin
      mem_m = ex_m;
      for (int k = 0; k < WAYS; k++) begin
        ex_m[k] = id_ent(k);
        ex_m[k].v = (k < exp_ic);
      end
    end
    @(negedge clock);
  endtask

  task automatic clear_id();
    id_valid = '0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = '0; id_rs2_used = '0;
    id_dest = '0; id_wr = '0; id_rd_mem = '0;
  endtask

  task automatic set_way(input int i, input int r1, input bit u1, input int r2, input bit u2,
                         input int d, input bit wr, input bit ld);
    id_rs1[i*RW +: RW] = RW'(r1); id_rs1_used[i] = u1;
    id_rs2[i*RW +: RW] = RW'(r2); id_rs2_used[i] = u2;
    id_dest[i*RW +: RW] = RW'(d); id_wr[i] = wr; id_rd_mem[i] = ld;
  endtask

  task automatic do_flush();
    clear_id(); flush = 1; settle(); advance(); flush = 0;
  endtask

  initial begin
    reset_n = 0; stall_in = 0; flush = 0;
    clear_id();
    clear_model();
    repeat (2) @(negedge clock);
    settle();
    reset_n = 1;

    // Intra-bundle RAW, then forward from EX way 0.
    set_way(0, 1, 1, 0, 0, 1, 1, 0); set_way(1, 1, 1, 0, 0, 2, 1, 0); set_way(2, 3, 1, 0, 0, 3, 1, 0);
    id_valid = 3'b111; settle();
    chk("raw_ic", 32'(issue_count), 32'd1);
    advance();
    clear_id(); id_valid = 3'b111; set_way(0, 1, 1, 0, 0, 2, 1, 0); settle();
    chk("raw_fwd_ex0", 32'(fwd_a[3:0]), 32'h4);
    advance();

    // Load-use on way 0, then MEM forward.
    do_flush();
    clear_id(); id_valid = 3'b001; set_way(0, 0, 1, 0, 0, 1, 1, 1); settle(); advance();
    clear_id(); id_valid = 3'b111; set_way(0, 1, 1, 0, 0, 1, 1, 0); settle();
    chk("lu_ic", 32'(issue_count), 32'd0);
    chk("lu_flag", 32'(load_use), 32'd1);
    advance(); settle();
    chk("lu_after_ic", 32'(issue_count), 32'd3);
    chk("lu_mem_fwd", 32'(fwd_a[3:0]), 32'h8);
    advance();

    // Load-use in way 2.
    do_flush();
    clear_id(); id_valid = 3'b111; set_way(2, 0, 1, 0, 0, 3, 1, 1); settle(); advance();
    clear_id(); id_valid = 3'b111;
    set_way(0, 1, 1, 0, 0, 1, 1, 0); set_way(1, 2, 1, 0, 0, 2, 1, 0); set_way(2, 3, 1, 0, 0, 3, 1, 0);
    settle();
    chk("lu2_ic", 32'(issue_count), 32'd2);
    chk("lu2_flag", 32'(load_use), 32'd1);
    advance();

    // Priority: youngest EX way beats MEM.
    do_flush();
    clear_id(); id_valid = 3'b001; set_way(0, 0, 0, 0, 0, 2, 1, 0); settle(); advance();
    clear_id(); id_valid = 3'b111; set_way(1, 0, 0, 0, 0, 1, 1, 0); set_way(2, 0, 0, 0, 0, 1, 1, 0);
    settle(); advance();
    clear_id(); id_valid = 3'b111; set_way(0, 1, 1, 2, 1, 3, 1, 0); settle();
    chk("prio_a", 32'(fwd_a[3:0]), 32'h6);
    chk("prio_b", 32'(fwd_b[3:0]), 32'h8);
    advance();

    // x0 never forwards.
    do_flush();
    clear_id(); id_valid = 3'b001; set_way(0, 0, 1, 0, 0, 0, 1, 0); settle(); advance();
    clear_id(); id_valid = 3'b111; set_way(0, 0, 1, 0, 1, 3, 1, 0); settle();
    chk("x0_ic", 32'(issue_count), 32'd3);
    chk("x0_fwd", 32'(fwd_a | fwd_b), 32'd0);
    advance();

    // Asynchronous reset with a load in EX.
    do_flush();
    clear_id(); id_valid = 3'b001; set_way(0, 0, 1, 0, 0, 5, 1, 1); settle(); advance();
    clear_id(); id_valid = 3'b111; set_way(0, 5, 1, 0, 0, 6, 1, 0); settle();
    chk("pre_rst_lu", 32'(load_use), 32'd1);
    reset_n = 0; #1;
    chk("rst_lu", 32'(load_use), 32'd0);
    chk("rst_ic", 32'(issue_count), 32'd3);
    clear_model();
    reset_n = 1;
    settle(); advance();

    // Stall holds shadows; flush beats stall.
    do_flush();
    clear_id(); id_valid = 3'b111;
    set_way(0, 0, 0, 0, 0, 1, 1, 0); set_way(1, 0, 0, 0, 0, 2, 1, 0); set_way(2, 0, 0, 0, 0, 3, 1, 0);
    settle(); advance();
    clear_id(); id_valid = 3'b111; set_way(0, 1, 1, 2, 1, 0, 0, 0); set_way(1, 3, 1, 0, 0, 0, 0, 0);
    stall_in = 1; settle();
    chk("stall_fwd_a", 32'(fwd_a), 32'h064);
    saved_a = 32'(fwd_a);
    for (int c = 0; c < 2; c++) begin
      advance(); settle();
      chk("stall_hold", 32'(fwd_a), saved_a);
    end
    flush = 1; settle(); advance();
    flush = 0; stall_in = 0; settle();
    chk("flush_fwd", 32'(fwd_a | fwd_b), 32'd0);
    advance();

    // Random bundles over a small register set to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      int nv;
      clear_id();
      nv = $urandom_range(0, WAYS);
      id_valid = 3'((1 << nv) - 1);
      for (int i = 0; i < WAYS; i++) begin
        bit w;
        w = 1'($urandom_range(0, 1));
        set_way(i, $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                1'($urandom_range(0, 1)), $urandom_range(0, 4), w, w & 1'($urandom_range(0, 1)));
      end
      stall_in = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      settle();
      if ($urandom_range(0, 49) == 0) begin
        reset_n = 0; #1;
        clear_model();
        predict();
        chk("rnd_rst_lu", 32'(load_use), 32'(exp_lu));
        chk("rnd_rst_ic", 32'(issue_count), 32'(exp_ic));
        reset_n = 1;
      end
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
